// File: rtl/ser3_deframer.sv
// ser3_deframer: rebuilds 3-bit words from a framed 1-bit serial stream.
// A SYNC-marked bit starts each frame; the third bit completes the word,
// which is then offered to a consumer through a VALID/READY handshake.
// Words completing while an earlier word is still unconsumed are dropped
// and flagged on the sticky OVF output.
module ser3_deframer #(
    parameter logic [2:0] INIT      = 3'b000,
    parameter logic       MSB_FIRST = 1'b1,
    parameter logic       INVERT_IN = 1'b1
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       CE,
    input  logic       SYNC,
    input  logic       D,
    input  logic       READY,
    output logic [2:0] Q,
    output logic       VALID,
    output logic       OVF,
    output logic       ERR
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       b0_q, b0_d;
    logic       b1_q, b1_d;
    logic [2:0] q_q, q_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;

    logic       cap_s;
    logic       complete_s;
    logic [2:0] word_s;

    // Polarity-corrected serial bit and the word it would complete
    always_comb begin
        cap_s = D ^ INVERT_IN;
        if (MSB_FIRST) begin
            word_s = {b0_q, b1_q, cap_s};
        end else begin
            word_s = {cap_s, b1_q, b0_q};
        end
    end

    // Frame tracking: SYNC restarts from any state, else advance one bit per CE
    always_comb begin
        state_d    = state_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        err_d      = 1'b0;
        complete_s = 1'b0;
        if (CE) begin
            if (SYNC) begin
                b0_d    = cap_s;
                state_d = B1;
                // A restart while a frame was in progress loses the partial
                err_d   = (state_q != HUNT) ? 1'b1 : 1'b0;
            end else begin
                case (state_q)
                    HUNT: begin
                        state_d = HUNT;
                    end
                    B1: begin
                        b1_d    = cap_s;
                        state_d = B2;
                    end
                    B2: begin
                        complete_s = 1'b1;
                        state_d    = HUNT;
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output handshake: transfer, load of a fresh word, or drop with overflow
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && READY) begin
            // Consumer takes the current word; a word finishing now replaces it
            if (complete_s) begin
                q_d     = word_s;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (valid_q) begin
            // Consumer stalled: Q must stay stable, so a new word is lost
            if (complete_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end else begin
            if (complete_s) begin
                q_d     = word_s;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously by CLR
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= HUNT;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            q_q     <= INIT;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_ser3_deframer.sv
// Testbench for ser3_deframer: two instances share one stimulus stream,
// A with default parameters, B with LSB-first, non-inverted input and a
// non-zero INIT. A frame-level model predicts every output each cycle,
// and directed checks pin hand-computed words at key points.
module tb_ser3_deframer;

    logic       C, CLR, CE, SYNC, D, READY;
    logic [2:0] qa, qb;
    logic       va, vb, oa, ob, ea, eb;

    ser3_deframer u_a (
        .C(C), .CLR(CLR), .CE(CE), .SYNC(SYNC), .D(D), .READY(READY),
        .Q(qa), .VALID(va), .OVF(oa), .ERR(ea)
    );

    ser3_deframer #(
        .INIT(3'b101), .MSB_FIRST(1'b0), .INVERT_IN(1'b0)
    ) u_b (
        .C(C), .CLR(CLR), .CE(CE), .SYNC(SYNC), .D(D), .READY(READY),
        .Q(qb), .VALID(vb), .OVF(ob), .ERR(eb)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 C = ~C;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    function automatic bit msb_of(input int k);
        return (k == 0);
    endfunction
    function automatic bit inv_of(input int k);
        return (k == 0);
    endfunction
    function automatic logic [2:0] init_of(input int k);
        return (k == 0) ? 3'b000 : 3'b101;
    endfunction

    int         m_n[2];
    bit [2:0]   m_bits[2];
    logic [2:0] m_q[2];
    bit         m_valid[2], m_ovf[2], m_err[2];
    bit         t_done;
    logic [2:0] t_word;
    bit         t_bit;

    always @(posedge C or posedge CLR) begin
        if (CLR) begin
            for (int k = 0; k < 2; k++) begin
                m_n[k] = 0; m_bits[k] = 3'b000; m_q[k] = init_of(k);
                m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                t_done = 1'b0; t_word = 3'b000; m_err[k] = 1'b0;
                t_bit = D ^ inv_of(k);
                if (CE) begin
                    if (SYNC) begin
                        m_err[k] = (m_n[k] != 0);
                        m_bits[k][0] = t_bit;
                        m_n[k] = 1;
                    end else if (m_n[k] > 0) begin
                        m_bits[k][m_n[k]] = t_bit;
                        m_n[k] = m_n[k] + 1;
                        if (m_n[k] == 3) begin
                            t_done = 1'b1;
                            m_n[k] = 0;
                            for (int i = 0; i < 3; i++) begin
                                if (msb_of(k)) t_word[2-i] = m_bits[k][i];
                                else           t_word[i]   = m_bits[k][i];
                            end
                        end
                    end
                end
                if (t_done) begin
                    if (!m_valid[k] || READY) begin
                        m_q[k] = t_word; m_valid[k] = 1'b1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end else if (m_valid[k] && READY) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge
    always @(negedge C) begin
        if (chk_en) begin
            chk("A_Q", qa, m_q[0]);
            chk("A_VALID", {2'b00, va}, {2'b00, m_valid[0]});
            chk("A_OVF", {2'b00, oa}, {2'b00, m_ovf[0]});
            chk("A_ERR", {2'b00, ea}, {2'b00, m_err[0]});
            chk("B_Q", qb, m_q[1]);
            chk("B_VALID", {2'b00, vb}, {2'b00, m_valid[1]});
            chk("B_OVF", {2'b00, ob}, {2'b00, m_ovf[1]});
            chk("B_ERR", {2'b00, eb}, {2'b00, m_err[1]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ce, input logic sync, input logic d, input logic rdy);
        @(negedge C);
        CE = ce; SYNC = sync; D = d; READY = rdy;
    endtask

    task automatic after_edge;
        @(posedge C);
        #1;
    endtask

    initial begin
        C = 1'b0; CLR = 1'b1; CE = 1'b0; SYNC = 1'b0; D = 1'b0; READY = 1'b0;
        // 1) reset is asynchronous: no clock edge has happened yet
        #2;
        chk("rst_A_Q", qa, 3'b000);
        chk("rst_B_Q", qb, 3'b101);
        chk("rst_A_VALID", {2'b00, va}, 3'b000);
        chk("rst_A_OVF", {2'b00, oa}, 3'b000);
        chk("rst_A_ERR", {2'b00, ea}, 3'b000);
        #10 CLR = 1'b0;
        chk_en = 1'b1;

        // 2) D=0,1,1 with SYNC on first bit, READY=1
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge;
        chk("t2_A_VALID_early", {2'b00, va}, 3'b000);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge;
        chk("t2_A_Q", qa, 3'b100);
        chk("t2_A_VALID", {2'b00, va}, 3'b001);
        chk("t2_B_Q", qb, 3'b110);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t2_A_VALID_drop", {2'b00, va}, 3'b000);
        chk("t2_A_Q_hold", qa, 3'b100);

        // 3) D=1,1,0 with CE toggling 1,0,1,0,1
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        after_edge;
        chk("t3_B_VALID_ce0", {2'b00, vb}, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t3_B_Q", qb, 3'b011);
        chk("t3_B_VALID", {2'b00, vb}, 3'b001);
        chk("t3_A_Q", qa, 3'b001);

        // 4) SYNC again on the second bit of a frame
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        after_edge;
        chk("t4_A_ERR", {2'b00, ea}, 3'b001);
        chk("t4_A_VALID", {2'b00, va}, 3'b000);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge;
        chk("t4_A_ERR_clr", {2'b00, ea}, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t4_A_Q", qa, 3'b101);
        chk("t4_B_Q", qb, 3'b010);

        // 5) READY=0 across two complete frames
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        after_edge;
        chk("t5_A_Q1", qa, 3'b011);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        after_edge;
        chk("t5_A_Q_held", qa, 3'b011);
        chk("t5_A_OVF", {2'b00, oa}, 3'b001);
        chk("t5_B_Q_held", qb, 3'b001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t5_A_VALID_xfer", {2'b00, va}, 3'b000);
        chk("t5_A_OVF_sticky", {2'b00, oa}, 3'b001);

        // CLR pulse mid-frame, between clock edges
        step(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge C);
        #2 CLR = 1'b1;
        #1;
        chk("clr_A_Q", qa, 3'b000);
        chk("clr_B_Q", qb, 3'b101);
        chk("clr_A_OVF", {2'b00, oa}, 3'b000);
        chk("clr_B_OVF", {2'b00, ob}, 3'b000);
        #1 CLR = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge;
        chk("clr_A_ERR", {2'b00, ea}, 3'b000);

        // 6) word completes on a transfer edge
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge;
        chk("t6_B_Q1", qb, 3'b111);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t6_A_Q", qa, 3'b101);
        chk("t6_A_VALID", {2'b00, va}, 3'b001);
        chk("t6_A_OVF", {2'b00, oa}, 3'b000);
        chk("t6_B_Q", qb, 3'b010);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        after_edge;
        chk("t6_A_VALID_end", {2'b00, va}, 3'b000);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge C);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
